// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared bit indices, button count and repeat-FSM encoding
package button_pkg;

    // Bit positions of each pushbutton within btn_raw / btn_level / btn_press / btn_release
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_UP    = 2;
    localparam int BTN_DOWN  = 3;
    localparam int BTN_COUNT = 4;

    // Per-channel auto-repeat state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one-bit synchronizer, debouncer and auto-repeat FSM
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn_raw     unsynchronized pushbutton pin
//   btn_level   debounced active-high level
//   btn_press   one-cycle pulse on debounced press and on each auto-repeat
//   btn_release one-cycle pulse on debounced release
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int              DCW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0]  DEB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
    localparam int              RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              RCW         = $clog2(RPT_MAX + 1);
    localparam logic [RCW-1:0]  DELAY_LAST  = RCW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RCW-1:0]  PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);
    localparam bit              REPEAT_EN   = (REPEAT_DELAY > 0);

    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           stable_q, stable_d;
    logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    rep_state_t     state_q, state_d;
    logic [RCW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic           raw_in;
    logic           rise;
    logic           fall;

    assign raw_in = btn_raw ^ ACTIVE_LOW;

    // Debounce decision. stable_q is the accepted level; it is re-registered
    // into level_q so the visible level and its press/release pulses appear
    // together one cycle after the decision.
    always_comb begin
        sync1_d   = raw_in;
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DCW'(1);
            end
        end
        level_d = stable_q;
    end

    assign rise = stable_q & ~level_q;
    assign fall = ~stable_q & level_q;

    // State register (all channel flops)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    // Next-state logic. A fall always returns to IDLE, overriding any repeat.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (rise) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (REPEAT_EN && (rpt_cnt_q == DELAY_LAST)) begin
                    state_d = ST_REPEAT;
                end else if (REPEAT_EN) begin
                    rpt_cnt_d = rpt_cnt_q + RCW'(1);
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (rpt_cnt_q != PERIOD_LAST) begin
                    rpt_cnt_d = rpt_cnt_q + RCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        press_d   = 1'b0;
        release_d = fall;
        case (state_q)
            ST_IDLE:   press_d = rise;
            ST_HOLD:   press_d = !fall && REPEAT_EN && (rpt_cnt_q == DELAY_LAST);
            ST_REPEAT: press_d = !fall && (rpt_cnt_q == PERIOD_LAST);
            default:   press_d = 1'b0;
        endcase
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - four independent debounced, auto-repeating button channels
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn_raw     raw pins: bit0 right, bit1 left, bit2 up, bit3 down
//   btn_level   debounced active-high levels
//   btn_press   press / auto-repeat pulses
//   btn_release release pulses
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_COUNT-1:0] btn_raw,
    output logic [BTN_COUNT-1:0] btn_level,
    output logic [BTN_COUNT-1:0] btn_press,
    output logic [BTN_COUNT-1:0] btn_release
);

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner
module tb_button_conditioner;
    import button_pkg::*;

    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int HLEN = DEB + 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] btn_raw = 4'b0;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int n_checks = 0;
    int n_errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .ACTIVE_LOW      (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the raw samples taken 3..6
    // edges ago all show the new value; repeats follow rise time arithmetic.
    logic [HLEN-1:0] m_hist [4];
    logic [3:0]      m_level;
    logic [3:0]      m_press;
    logic [3:0]      m_release;
    int              m_rise_t [4];
    int              m_edge = 0;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
    endtask

    task automatic model_step();
        m_edge++;
        for (int i = 0; i < 4; i++) begin
            logic want;
            logic agree;
            int   d;
            m_press[i]   = 1'b0;
            m_release[i] = 1'b0;
            want  = ~m_level[i];
            agree = 1'b1;
            for (int k = 2; k < HLEN; k++) if (m_hist[i][k] != want) agree = 1'b0;
            if (agree) begin
                m_level[i] = want;
                if (want) begin
                    m_press[i]  = 1'b1;
                    m_rise_t[i] = m_edge;
                end else begin
                    m_release[i] = 1'b1;
                end
            end else if (m_level[i] && RD > 0) begin
                d = m_edge - m_rise_t[i];
                if (d >= RD && ((d - RD) % RP) == 0) m_press[i] = 1'b1;
            end
            m_hist[i] = {m_hist[i][HLEN-2:0], btn_raw[i]};
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else        model_step();
    end

    always @(negedge clk) begin
        check("level",   btn_level,   m_level);
        check("press",   btn_press,   m_press);
        check("release", btn_release, m_release);
        check("excl",    btn_press & btn_release, 4'b0);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        int lat;

        // Reset state
        edges(3);
        check("rst_level",   btn_level,   4'b0);
        check("rst_press",   btn_press,   4'b0);
        check("rst_release", btn_release, 4'b0);
        #2 rst_n = 1'b1;
        edges(2);

        // Clean press on right: sampled at E, visible at E+6 only
        btn_raw[BTN_RIGHT] = 1'b1;
        edges(6);
        check("clean_e5_level", btn_level[0], 1'b0);
        check("clean_e5_press", btn_press[0], 1'b0);
        edges(1);
        check("clean_e6_level", btn_level[0], 1'b1);
        check("clean_e6_press", btn_press[0], 1'b1);
        edges(1);
        check("clean_e7_press", btn_press[0], 1'b0);
        btn_raw[BTN_RIGHT] = 1'b0;
        edges(12);
        check("clean_rel_level", btn_level[0], 1'b0);

        // Bounce on up: 2-sample runs never reach the debounce threshold
        for (int k = 0; k < 4; k++) begin
            btn_raw[BTN_UP] = ~k[0];
            edges(2);
            check("bounce_lvl_mid", btn_level[2], 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            edges(1);
            check("bounce_level",   btn_level,   4'b0);
            check("bounce_press",   btn_press,   4'b0);
            check("bounce_release", btn_release, 4'b0);
        end

        // Auto-repeat on down, released so the fall lands on a repeat edge
        btn_raw[BTN_DOWN] = 1'b1;
        found = 0;
        lat   = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            edges(1);
            if (btn_press[3]) begin
                found = 1;
                lat   = k;
            end
        end
        check("rpt_found",   found, 1);
        check("rpt_latency", lat,   6);
        for (int t = 1; t <= 18; t++) begin
            edges(1);
            if (t != 16) check("rpt_press", btn_press[3], (t == 10 || t == 13));
            if (t == 9) btn_raw[BTN_DOWN] = 1'b0;
            if (t == 16) begin
                check("rpt_fall_release", btn_release[3], 1'b1);
                check("rpt_fall_press",   btn_press[3],   1'b0);
                check("rpt_fall_idle",    dut.g_chan[3].u_chan.state_q, ST_IDLE);
            end
        end

        // Reset mid-debounce with buttons held
        edges(4);
        btn_raw = 4'b0001;
        edges(10);
        check("pre_rst_level", btn_level, 4'b0001);
        btn_raw[BTN_LEFT] = 1'b1;
        edges(3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_level",   btn_level,   4'b0);
        check("midrst_press",   btn_press,   4'b0);
        check("midrst_release", btn_release, 4'b0);
        edges(2);
        #2 rst_n = 1'b1;
        edges(6);
        check("postrst_e5_press", btn_press, 4'b0);
        edges(1);
        check("postrst_e6_press", btn_press, 4'b0011);
        check("postrst_e6_level", btn_level, 4'b0011);

        // Simultaneous right+left
        btn_raw = 4'b0000;
        edges(12);
        btn_raw = 4'b0011;
        found = 0;
        lat   = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            edges(1);
            if (btn_press != 4'b0) begin
                found = 1;
                lat   = k;
            end
        end
        check("simul_found",   found,     1);
        check("simul_latency", lat,       6);
        check("simul_press",   btn_press, 4'b0011);
        check("simul_level",   btn_level, 4'b0011);
        btn_raw = 4'b0000;
        edges(12);

        // Randomized activity, occasional asynchronous reset
        for (int k = 0; k < 300; k++) begin
            int b;
            int hold;
            b    = $urandom_range(0, 3);
            hold = $urandom_range(1, 20);
            btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                edges(1);
                #2 rst_n = 1'b1;
            end
            edges(hold);
        end

        btn_raw = 4'b0000;
        edges(15);
        check("final_level", btn_level, 4'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
